// File: rtl/hi_setget_bist.sv
// Host-interface set/get self-test master.
// For each terminal: write a pattern to COUNT registers (SET), read them back and
// compare (GET), then read the first register once as a reference and REPEATS
// more times, checking that every read matches it (BB0/BB).
module hi_setget_bist #(
  parameter int NUM_TERMS = 2,
  parameter int TERM_BASE = 0,
  parameter int REG_BASE  = 0,
  parameter int COUNT     = 160,
  parameter int REPEATS   = 10,
  parameter int DATA_W    = 16,
  parameter int TIMEOUT   = 1023
) (
  input  logic              i_ifclk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [1:0]        i_pattern_sel,
  input  logic [DATA_W-1:0] i_seed,
  output logic [15:0]       o_term_addr,
  output logic [31:0]       o_reg_addr,
  output logic              o_wr_req,
  output logic [DATA_W-1:0] o_wr_data,
  input  logic              i_wr_ack,
  output logic              o_rd_req,
  input  logic              i_rd_valid,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_timeout_err,
  output logic [15:0]       o_err_count,
  output logic [31:0]       o_fail_addr,
  output logic [15:0]       o_fail_term,
  output logic [DATA_W-1:0] o_fail_data
);

  typedef enum logic [2:0] {S_IDLE, S_SET, S_GET, S_BB0, S_BB, S_NXT, S_FIN} state_t;

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_i, r_k, r_tmo_cnt;
  logic [15:0]       r_t;
  logic              r_wr_req, r_rd_req;
  logic [15:0]       r_term_addr;
  logic [31:0]       r_reg_addr;
  logic [DATA_W-1:0] r_wr_data, r_ref, r_seed;
  logic [1:0]        r_sel;
  logic              r_pass, r_timeout_err;
  logic [15:0]       r_err_count;
  logic [31:0]       r_fail_addr;
  logic [15:0]       r_fail_term;
  logic [DATA_W-1:0] r_fail_data;
  logic              w_busy, w_done;

  // Test pattern for index idx; only the low DATA_W bits of idx take part.
  function automatic logic [DATA_W-1:0] f_pattern(input logic [1:0] sel,
                                                  input logic [DATA_W-1:0] seed,
                                                  input logic [31:0] idx);
    logic [DATA_W-1:0] lo;
    lo = idx[DATA_W-1:0];
    case (sel)
      2'd0:    f_pattern = lo;
      2'd1:    f_pattern = ~lo;
      2'd2:    f_pattern = {{(DATA_W-1){1'b0}}, 1'b1} << (idx % 32'(DATA_W));
      default: f_pattern = lo ^ seed;
    endcase
  endfunction

  // Error counter increment that sticks at all-ones.
  function automatic logic [15:0] f_sat_inc(input logic [15:0] v);
    f_sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic              w_wr_fire, w_rd_fire, w_pend, w_tmo;
  logic              w_last_i, w_last_k, w_last_t, w_mis;
  logic [DATA_W-1:0] w_exp;

  assign w_wr_fire = r_wr_req & i_wr_ack;
  assign w_rd_fire = r_rd_req & i_rd_valid;
  assign w_pend    = r_wr_req | r_rd_req;
  assign w_tmo     = w_pend & ~(w_wr_fire | w_rd_fire) & (r_tmo_cnt == 32'(TIMEOUT));
  assign w_last_i  = (r_i == 32'(COUNT - 1));
  assign w_last_k  = (r_k == 32'(REPEATS - 1));
  assign w_last_t  = (r_t == 16'(NUM_TERMS - 1));
  assign w_exp     = (r_state == S_BB) ? r_ref : f_pattern(r_sel, r_seed, r_i);
  assign w_mis     = w_rd_fire & ((r_state == S_GET) | (r_state == S_BB)) & (i_rd_data != w_exp);

  // State register.
  always_ff @(posedge i_ifclk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; a timeout aborts any request-issuing phase.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = S_SET;
      S_SET:  if (w_tmo) w_state_nxt = S_FIN;
              else if (w_wr_fire && w_last_i) w_state_nxt = S_GET;
      S_GET:  if (w_tmo) w_state_nxt = S_FIN;
              else if (w_rd_fire && w_last_i) w_state_nxt = S_BB0;
      S_BB0:  if (w_tmo) w_state_nxt = S_FIN;
              else if (w_rd_fire) w_state_nxt = S_BB;
      S_BB:   if (w_tmo) w_state_nxt = S_FIN;
              else if (w_rd_fire && w_last_k) w_state_nxt = S_NXT;
      S_NXT:  w_state_nxt = w_last_t ? S_FIN : S_SET;
      S_FIN:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs: busy while sequencing, done for the single FIN cycle.
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE:  ;
      S_FIN:   w_done = 1'b1;
      default: w_busy = 1'b1;
    endcase
  end

  // Bus requests, indices, timeout counter and result capture.
  always_ff @(posedge i_ifclk) begin
    if (i_reset) begin
      r_i <= '0; r_k <= '0; r_t <= '0; r_tmo_cnt <= '0;
      r_wr_req <= 1'b0; r_rd_req <= 1'b0;
      r_term_addr <= '0; r_reg_addr <= '0; r_wr_data <= '0;
      r_ref <= '0; r_seed <= '0; r_sel <= '0;
      r_pass <= 1'b0; r_timeout_err <= 1'b0; r_err_count <= '0;
      r_fail_addr <= '0; r_fail_term <= '0; r_fail_data <= '0;
    end else begin
      // Counts cycles a request has been waiting; any ack/valid restarts it.
      if (!w_pend || w_wr_fire || w_rd_fire) r_tmo_cnt <= '0;
      else                                   r_tmo_cnt <= r_tmo_cnt + 32'd1;
      if (w_tmo) begin
        r_wr_req      <= 1'b0;
        r_rd_req      <= 1'b0;
        r_timeout_err <= 1'b1;
      end
      // err_count still zero means this is the first mismatch of the run.
      if (w_mis) begin
        r_err_count <= f_sat_inc(r_err_count);
        if (r_err_count == 16'd0) begin
          r_fail_addr <= r_reg_addr;
          r_fail_term <= r_term_addr;
          r_fail_data <= i_rd_data;
        end
      end
      case (r_state)
        S_IDLE: if (i_start) begin
          r_i <= '0; r_t <= '0; r_k <= '0;
          r_sel <= i_pattern_sel; r_seed <= i_seed;
          r_pass <= 1'b0; r_timeout_err <= 1'b0; r_err_count <= '0;
          r_fail_addr <= '0; r_fail_term <= '0; r_fail_data <= '0;
        end
        S_SET: if (w_wr_fire) begin
          r_wr_req <= 1'b0;
          r_i      <= w_last_i ? 32'd0 : r_i + 32'd1;
        end else if (!r_wr_req) begin
          r_wr_req    <= 1'b1;
          r_term_addr <= 16'(TERM_BASE) + r_t;
          r_reg_addr  <= 32'(REG_BASE) + r_i;
          r_wr_data   <= f_pattern(r_sel, r_seed, r_i);
        end
        S_GET: if (w_rd_fire) begin
          r_rd_req <= 1'b0;
          r_i      <= w_last_i ? 32'd0 : r_i + 32'd1;
        end else if (!r_rd_req) begin
          r_rd_req    <= 1'b1;
          r_term_addr <= 16'(TERM_BASE) + r_t;
          r_reg_addr  <= 32'(REG_BASE) + r_i;
        end
        S_BB0, S_BB: if (w_rd_fire) begin
          r_rd_req <= 1'b0;
          if (r_state == S_BB0) begin
            r_ref <= i_rd_data;
            r_k   <= '0;
          end else begin
            r_k <= r_k + 32'd1;
          end
        end else if (!r_rd_req) begin
          r_rd_req    <= 1'b1;
          r_term_addr <= 16'(TERM_BASE) + r_t;
          r_reg_addr  <= 32'(REG_BASE);
        end
        S_NXT: if (w_last_t) r_pass <= (r_err_count == 16'd0) && !r_timeout_err;
               else          r_t    <= r_t + 16'd1;
        default: ;
      endcase
    end
  end

  assign o_term_addr   = r_term_addr;
  assign o_reg_addr    = r_reg_addr;
  assign o_wr_req      = r_wr_req;
  assign o_wr_data     = r_wr_data;
  assign o_rd_req      = r_rd_req;
  assign o_busy        = w_busy;
  assign o_done        = w_done;
  assign o_pass        = r_pass;
  assign o_timeout_err = r_timeout_err;
  assign o_err_count   = r_err_count;
  assign o_fail_addr   = r_fail_addr;
  assign o_fail_term   = r_fail_term;
  assign o_fail_data   = r_fail_data;

endmodule
